// File: rtl/sound_cmd_mailbox.sv
// Command mailbox between the main CPU and the Z80 sound CPU: DEPTH-entry
// command FIFO, a reply latch going back, and the Z80 INT_n / IM0 vector merge.
module sound_cmd_mailbox #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int NIRQ      = 1,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic            CLK_32M,
  input  logic            RESET_n,
  input  logic            flush,
  input  logic            main_wr,
  input  logic [DW-1:0]   main_din,
  input  logic            main_rd,
  output logic [DW-1:0]   main_dout,
  output logic            reply_valid,
  output logic            full,
  output logic            overflow,
  input  logic            snd_ack,
  output logic [DW-1:0]   snd_dout,
  output logic            cmd_pending,
  input  logic            snd_reply_wr,
  input  logic [DW-1:0]   snd_reply_din,
  input  logic [NIRQ-1:0] ext_irq_n,
  output logic            int_n,
  output logic [7:0]      int_vector
);

  // DEPTH=1 still gets a 1-bit pointer; the wrap logic pins it to zero.
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int MEMN = 1 << AW;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q [MEMN];
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] memAddr;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          replyValid_q, replyValid_d;
  logic [DW-1:0] replyData_q, replyData_d;
  logic          intN_q, intN_d;
  logic [7:0]    vector_q, vector_d;
  logic          memWe;
  logic          notEmpty, isFull;
  logic          popOk, pushOk, pushBlocked;
  logic [1:0]    irqN;

  function automatic logic [AW-1:0] ptrInc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] ptrDec(input logic [AW-1:0] p);
    return (p == '0) ? LAST_PTR : p - 1'b1;
  endfunction

  generate
    if (NIRQ >= 2) begin : gTwoIrq
      assign irqN = ext_irq_n[1:0];
    end else begin : gOneIrq
      assign irqN = {1'b1, ext_irq_n[0]};
    end
  endgenerate

  assign notEmpty    = (count_q != '0);
  assign isFull      = (count_q == FULL_CNT);
  assign popOk       = snd_ack & notEmpty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign pushOk      = main_wr & (~isFull | snd_ack);
  assign pushBlocked = main_wr & isFull & ~snd_ack;

  always_comb begin
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    replyValid_d = replyValid_q;
    replyData_d  = replyData_q;
    memWe        = 1'b0;
    memAddr      = wrPtr_q;
    if (flush) begin
      rdPtr_d      = '0;
      wrPtr_d      = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      replyValid_d = 1'b0;
    end else begin
      if (popOk) begin
        rdPtr_d = ptrInc(rdPtr_q);
      end
      if (pushOk) begin
        memWe   = 1'b1;
        wrPtr_d = ptrInc(wrPtr_q);
      end else if (pushBlocked) begin
        if (OVERWRITE) begin
          memWe   = 1'b1;
          memAddr = ptrDec(wrPtr_q);
        end else begin
          overflow_d = 1'b1;
        end
      end
      case ({pushOk, popOk})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (snd_reply_wr) begin
        replyData_d  = snd_reply_din;
        replyValid_d = 1'b1;
      end else if (main_rd) begin
        replyValid_d = 1'b0;
      end
    end
  end

  // Interrupt is level-driven from the registered FIFO state, one clock behind.
  always_comb begin
    intN_d   = ~(notEmpty | ~&irqN);
    vector_d = {2'b11, ~notEmpty, irqN[0], irqN[1], 3'b111};
  end

  always_ff @(posedge CLK_32M or negedge RESET_n) begin
    if (!RESET_n) begin
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      replyValid_q <= 1'b0;
      replyData_q  <= '0;
      intN_q       <= 1'b1;
      vector_q     <= 8'hFF;
    end else begin
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      replyValid_q <= replyValid_d;
      replyData_q  <= replyData_d;
      intN_q       <= intN_d;
      vector_q     <= vector_d;
    end
  end

  always_ff @(posedge CLK_32M) begin
    if (memWe) begin
      mem_q[memAddr] <= main_din;
    end
  end

  assign snd_dout    = mem_q[rdPtr_q];
  assign cmd_pending = notEmpty;
  assign full        = isFull;
  assign overflow    = overflow_q;
  assign main_dout   = replyData_q;
  assign reply_valid = replyValid_q;
  assign int_n       = intN_q;
  assign int_vector  = vector_q;

endmodule

// File: tb/tb_sound_cmd_mailbox.sv
// Bench for sound_cmd_mailbox: a 4-deep drop-on-full instance with two IRQs
// and a 1-deep overwrite instance, driven by vector tables, sequences and random traffic.
module tb_sound_cmd_mailbox;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       ack;
    logic       rd;
    logic       rwr;
    logic [7:0] rdin;
    logic [1:0] irq;
    logic       flush;
  } stim_t;

  typedef struct {
    logic       pend;
    logic       full;
    logic       ovf;
    logic       chkHead;
    logic [7:0] head;
    logic       rv;
    logic [7:0] mdout;
    logic       intN;
    logic [7:0] vec;
  } expect_t;

  typedef struct {
    stim_t   s;
    expect_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic       aWr, aAck, aRd, aRwr, aFlush;
  logic [7:0] aDin, aRdin;
  logic [1:0] aIrq;
  logic [7:0] aDout, aHead, aVec;
  logic       aRv, aFull, aOvf, aPend, aIntN;

  logic       bWr, bAck, bRd, bRwr, bFlush;
  logic [7:0] bDin, bRdin;
  logic [0:0] bIrq;
  logic [7:0] bDout, bHead, bVec;
  logic       bRv, bFull, bOvf, bPend, bIntN;

  int testsRun    = 0;
  int testsFailed = 0;

  vec_t tbl[$];

  logic [7:0] mq[$];
  logic       mOvf, mRv, mIntN;
  logic [7:0] mDout, mVec;

  sound_cmd_mailbox #(.DW(8), .DEPTH(4), .NIRQ(2), .OVERWRITE(1'b0)) dutA (
    .CLK_32M(clk), .RESET_n(rstN), .flush(aFlush),
    .main_wr(aWr), .main_din(aDin), .main_rd(aRd), .main_dout(aDout),
    .reply_valid(aRv), .full(aFull), .overflow(aOvf),
    .snd_ack(aAck), .snd_dout(aHead), .cmd_pending(aPend),
    .snd_reply_wr(aRwr), .snd_reply_din(aRdin), .ext_irq_n(aIrq),
    .int_n(aIntN), .int_vector(aVec)
  );

  sound_cmd_mailbox #(.DW(8), .DEPTH(1), .NIRQ(1), .OVERWRITE(1'b1)) dutB (
    .CLK_32M(clk), .RESET_n(rstN), .flush(bFlush),
    .main_wr(bWr), .main_din(bDin), .main_rd(bRd), .main_dout(bDout),
    .reply_valid(bRv), .full(bFull), .overflow(bOvf),
    .snd_ack(bAck), .snd_dout(bHead), .cmd_pending(bPend),
    .snd_reply_wr(bRwr), .snd_reply_din(bRdin), .ext_irq_n(bIrq),
    .int_n(bIntN), .int_vector(bVec)
  );

  function automatic stim_t st(logic wr, logic [7:0] din, logic ack, logic rd,
                               logic rwr, logic [7:0] rdin, logic [1:0] irq, logic fl);
    stim_t r;
    r.wr = wr; r.din = din; r.ack = ack; r.rd = rd;
    r.rwr = rwr; r.rdin = rdin; r.irq = irq; r.flush = fl;
    return r;
  endfunction

  function automatic expect_t ex(logic pend, logic full, logic ovf, logic chk, logic [7:0] head,
                                 logic rv, logic [7:0] mdout, logic intN, logic [7:0] vec);
    expect_t r;
    r.pend = pend; r.full = full; r.ovf = ovf; r.chkHead = chk; r.head = head;
    r.rv = rv; r.mdout = mdout; r.intN = intN; r.vec = vec;
    return r;
  endfunction

  task automatic addRow(input stim_t s, input expect_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    tbl.push_back(v);
  endtask

  // Reference model: a bounded queue, a sticky flag and a reply latch.
  task automatic modelReset();
    mq.delete();
    mOvf  = 1'b0;
    mRv   = 1'b0;
    mDout = 8'h00;
    mIntN = 1'b1;
    mVec  = 8'hFF;
  endtask

  task automatic modelStep(input stim_t s);
    logic       pendPre, wasFull, nIntN;
    logic [7:0] nVec, junk;
    pendPre = (mq.size() != 0);
    wasFull = (mq.size() == 4);
    nIntN   = ~(pendPre | (s.irq != 2'b11));
    nVec    = {2'b11, ~pendPre, s.irq[0], s.irq[1], 3'b111};
    if (s.flush) begin
      mq.delete();
      mOvf = 1'b0;
      mRv  = 1'b0;
    end else begin
      if (s.ack && pendPre) junk = mq.pop_front();
      if (s.wr) begin
        if (!wasFull || s.ack) mq.push_back(s.din);
        else mOvf = 1'b1;
      end
      if (s.rwr) begin
        mDout = s.rdin;
        mRv   = 1'b1;
      end else if (s.rd) begin
        mRv = 1'b0;
      end
    end
    mIntN = nIntN;
    mVec  = nVec;
  endtask

  task automatic applyStimulus(input stim_t s);
    aWr = s.wr; aDin = s.din; aAck = s.ack; aRd = s.rd;
    aRwr = s.rwr; aRdin = s.rdin; aIrq = s.irq; aFlush = s.flush;
    @(posedge clk);
    #1;
    modelStep(s);
    aWr = 1'b0; aAck = 1'b0; aRd = 1'b0; aRwr = 1'b0; aFlush = 1'b0;
    bWr = 1'b0; bAck = 1'b0; bRd = 1'b0; bRwr = 1'b0; bFlush = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRow(input int i, input expect_t e);
    checkOutput($sformatf("row%0d pending", i), aPend, e.pend);
    checkOutput($sformatf("row%0d full", i), aFull, e.full);
    checkOutput($sformatf("row%0d overflow", i), aOvf, e.ovf);
    if (e.chkHead) checkOutput($sformatf("row%0d snd_dout", i), aHead, e.head);
    checkOutput($sformatf("row%0d reply_valid", i), aRv, e.rv);
    checkOutput($sformatf("row%0d main_dout", i), aDout, e.mdout);
    checkOutput($sformatf("row%0d int_n", i), aIntN, e.intN);
    checkOutput($sformatf("row%0d int_vector", i), aVec, e.vec);
  endtask

  task automatic checkModel(input int i);
    checkOutput($sformatf("rnd%0d pending", i), aPend, (mq.size() != 0));
    checkOutput($sformatf("rnd%0d full", i), aFull, (mq.size() == 4));
    checkOutput($sformatf("rnd%0d overflow", i), aOvf, mOvf);
    if (mq.size() != 0) checkOutput($sformatf("rnd%0d snd_dout", i), aHead, mq[0]);
    checkOutput($sformatf("rnd%0d reply_valid", i), aRv, mRv);
    checkOutput($sformatf("rnd%0d main_dout", i), aDout, mDout);
    checkOutput($sformatf("rnd%0d int_n", i), aIntN, mIntN);
    checkOutput($sformatf("rnd%0d int_vector", i), aVec, mVec);
  endtask

  initial begin
    stim_t idle, s;
    logic [1:0] curIrq;
    idle = st(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 1'b0);

    rstN = 1'b0;
    aWr = 0; aDin = 0; aAck = 0; aRd = 0; aRwr = 0; aRdin = 0; aIrq = 2'b11; aFlush = 0;
    bWr = 0; bDin = 0; bAck = 0; bRd = 0; bRwr = 0; bRdin = 0; bIrq = 1'b1; bFlush = 0;
    modelReset();

    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset A int_n", aIntN, 1'b1);
    checkOutput("reset A int_vector", aVec, 8'hFF);
    checkOutput("reset A full", aFull, 1'b0);
    checkOutput("reset A pending", aPend, 1'b0);
    checkOutput("reset A main_dout", aDout, 8'h00);
    checkOutput("reset A reply_valid", aRv, 1'b0);
    checkOutput("reset A overflow", aOvf, 1'b0);
    checkOutput("reset B int_vector", bVec, 8'hFF);
    checkOutput("reset B pending", bPend, 1'b0);
    rstN = 1'b1;

    // Fill/drain, empty ack, IRQ merge, reply latch and flush on the 4-deep instance.
    addRow(st(1, 8'h11, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 0, 1, 8'h11, 0, 8'h00, 1, 8'hFF));
    addRow(st(1, 8'h22, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 0, 1, 8'h11, 0, 8'h00, 0, 8'hDF));
    addRow(st(1, 8'h33, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 0, 1, 8'h11, 0, 8'h00, 0, 8'hDF));
    addRow(st(1, 8'h44, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 1, 0, 1, 8'h11, 0, 8'h00, 0, 8'hDF));
    addRow(st(1, 8'h55, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 1, 1, 1, 8'h11, 0, 8'h00, 0, 8'hDF));
    addRow(st(0, 8'h00, 1, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 1, 1, 8'h22, 0, 8'h00, 0, 8'hDF));
    addRow(st(0, 8'h00, 1, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 1, 1, 8'h33, 0, 8'h00, 0, 8'hDF));
    addRow(st(0, 8'h00, 1, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 1, 1, 8'h44, 0, 8'h00, 0, 8'hDF));
    addRow(st(0, 8'h00, 1, 0, 0, 8'h00, 2'b11, 0), ex(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 8'hDF));
    addRow(st(0, 8'h00, 1, 0, 0, 8'h00, 2'b11, 0), ex(0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 8'hFF));
    addRow(st(1, 8'h66, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 1, 1, 8'h66, 0, 8'h00, 1, 8'hFF));
    addRow(st(0, 8'h00, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 1, 1, 8'h66, 0, 8'h00, 0, 8'hDF));
    addRow(st(0, 8'h00, 0, 0, 0, 8'h00, 2'b10, 0), ex(1, 0, 1, 1, 8'h66, 0, 8'h00, 0, 8'hCF));
    addRow(st(0, 8'h00, 0, 0, 0, 8'h00, 2'b00, 0), ex(1, 0, 1, 1, 8'h66, 0, 8'h00, 0, 8'hC7));
    addRow(st(0, 8'h00, 1, 0, 0, 8'h00, 2'b00, 0), ex(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 8'hC7));
    addRow(st(0, 8'h00, 0, 0, 0, 8'h00, 2'b11, 0), ex(0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 8'hFF));
    addRow(st(0, 8'h00, 0, 0, 1, 8'h3C, 2'b11, 0), ex(0, 0, 1, 0, 8'h00, 1, 8'h3C, 1, 8'hFF));
    addRow(st(0, 8'h00, 0, 1, 1, 8'h7E, 2'b11, 0), ex(0, 0, 1, 0, 8'h00, 1, 8'h7E, 1, 8'hFF));
    addRow(st(0, 8'h00, 0, 1, 0, 8'h00, 2'b11, 0), ex(0, 0, 1, 0, 8'h00, 0, 8'h7E, 1, 8'hFF));
    addRow(st(0, 8'h00, 0, 0, 1, 8'h99, 2'b11, 0), ex(0, 0, 1, 0, 8'h00, 1, 8'h99, 1, 8'hFF));
    addRow(st(1, 8'h01, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 1, 1, 8'h01, 1, 8'h99, 1, 8'hFF));
    addRow(st(1, 8'h02, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 1, 1, 8'h01, 1, 8'h99, 0, 8'hDF));
    addRow(st(1, 8'h03, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 1, 1, 8'h01, 1, 8'h99, 0, 8'hDF));
    addRow(st(1, 8'h04, 0, 0, 1, 8'h55, 2'b11, 1), ex(0, 0, 0, 0, 8'h00, 0, 8'h99, 0, 8'hDF));
    addRow(st(0, 8'h00, 0, 0, 0, 8'h00, 2'b11, 0), ex(0, 0, 0, 0, 8'h00, 0, 8'h99, 1, 8'hFF));
    addRow(st(1, 8'h07, 0, 0, 0, 8'h00, 2'b11, 0), ex(1, 0, 0, 1, 8'h07, 0, 8'h99, 1, 8'hFF));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].s);
      checkRow(i, tbl[i].e);
    end

    // Single-entry overwrite instance behaves as the classic latch.
    bWr = 1'b1; bDin = 8'hA5;
    applyStimulus(idle);
    checkOutput("B first push pending", bPend, 1'b1);
    checkOutput("B first push full", bFull, 1'b1);
    checkOutput("B first push snd_dout", bHead, 8'hA5);
    bWr = 1'b1; bDin = 8'h5A;
    applyStimulus(idle);
    checkOutput("B overwrite snd_dout", bHead, 8'h5A);
    checkOutput("B overwrite full", bFull, 1'b1);
    checkOutput("B overwrite overflow", bOvf, 1'b0);
    checkOutput("B overwrite int_vector", bVec, 8'hDF);
    bWr = 1'b1; bDin = 8'h3C; bAck = 1'b1;
    applyStimulus(idle);
    checkOutput("B push+ack snd_dout", bHead, 8'h3C);
    checkOutput("B push+ack full", bFull, 1'b1);
    bAck = 1'b1;
    applyStimulus(idle);
    checkOutput("B drain pending", bPend, 1'b0);
    checkOutput("B drain full", bFull, 1'b0);
    bIrq = 1'b0;
    applyStimulus(idle);
    checkOutput("B ext irq int_vector", bVec, 8'hEF);
    checkOutput("B ext irq int_n", bIntN, 1'b0);
    bIrq = 1'b1;
    applyStimulus(idle);
    checkOutput("B irq release int_vector", bVec, 8'hFF);
    checkOutput("B irq release int_n", bIntN, 1'b1);

    // Async reset between clock edges while commands and a reply are outstanding.
    applyStimulus(st(1, 8'h08, 0, 0, 1, 8'h12, 2'b11, 0));
    applyStimulus(st(1, 8'h09, 0, 0, 0, 8'h00, 2'b11, 0));
    checkOutput("pre-reset int_n", aIntN, 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async reset pending", aPend, 1'b0);
    checkOutput("async reset reply_valid", aRv, 1'b0);
    checkOutput("async reset main_dout", aDout, 8'h00);
    checkOutput("async reset int_n", aIntN, 1'b1);
    checkOutput("async reset int_vector", aVec, 8'hFF);
    #2;
    rstN = 1'b1;
    modelReset();

    // Push with ack on a full FIFO: new entry goes to the tail, count stays at 4.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(st(1, 8'hB1 + 8'(k), 0, 0, 0, 8'h00, 2'b11, 0));
    end
    checkOutput("fill full", aFull, 1'b1);
    applyStimulus(st(1, 8'hB5, 1, 0, 0, 8'h00, 2'b11, 0));
    checkOutput("full push+ack full", aFull, 1'b1);
    checkOutput("full push+ack overflow", aOvf, 1'b0);
    checkOutput("full push+ack snd_dout", aHead, 8'hB2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(st(0, 8'h00, 1, 0, 0, 8'h00, 2'b11, 0));
      checkOutput($sformatf("tail drain %0d", k), aHead, 8'hB3 + 8'(k));
    end
    applyStimulus(st(0, 8'h00, 1, 0, 0, 8'h00, 2'b11, 0));
    checkOutput("tail drain empty", aPend, 1'b0);

    curIrq = 2'b11;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) curIrq = 2'($urandom_range(0, 3));
      s = st(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 8'($urandom),
             curIrq, ($urandom_range(0, 31) == 0));
      applyStimulus(s);
      checkModel(i);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
